// File: rtl/sal_ddr2_pkg.sv
// ----------------------------------------------------------------------------
// sal_ddr2_pkg
// Shared definitions for the DDR2 command arbiter:
//   cmd_e      - command class code carried on the DFI command register
//   spc_cnt_w  - width of the bus-spacing down-counters for a set of timings
//   spc_load   - value loaded into a spacing counter when its command is granted
// No ports (package).
// ----------------------------------------------------------------------------
package sal_ddr2_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    // Counter width is $clog2(max T + 1), never narrower than one bit so the
    // counters stay legal even when every timing is 0.
    function automatic int spc_cnt_w(input int t_ccd, input int t_rrd,
                                     input int t_wtr, input int t_rtw);
        int m;
        m = t_ccd;
        if (t_rrd > m) m = t_rrd;
        if (t_wtr > m) m = t_wtr;
        if (t_rtw > m) m = t_rtw;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

    // A timing of 0 or 1 means back-to-back is allowed, i.e. load 0.
    function automatic int spc_load(input int t);
        return (t > 1) ? (t - 1) : 0;
    endfunction

endpackage

// File: rtl/sal_cmd_arbiter_if.sv
// ----------------------------------------------------------------------------
// sal_cmd_arbiter_if
// Bundle between the per-bank controllers and the command arbiter.
//   act/rd/wr/pre/ref_req  [NUM_BK]  per-bank requests (bank controllers drive)
//   act/rd/wr/pre/ref_gnt  [NUM_BK]  per-bank grants (arbiter drives)
//   cmd_valid/type/bank              registered command toward DFI
// Modports: master = bank-controller side, slave = arbiter side.
//
// Request/grant semantics: a bank raises a req bit and keeps it high until the
// matching gnt bit is seen; the gnt is a single-cycle pulse in the cycle the
// command is taken (req and gnt high together). A bank may drop req before it
// is granted. At most one gnt bit across all five vectors is high per cycle.
// ----------------------------------------------------------------------------
interface sal_cmd_arbiter_if #(
    parameter int NUM_BK = 8
);
    import sal_ddr2_pkg::*;

    localparam int BW = $clog2(NUM_BK);

    logic [NUM_BK-1:0] act_req;
    logic [NUM_BK-1:0] rd_req;
    logic [NUM_BK-1:0] wr_req;
    logic [NUM_BK-1:0] pre_req;
    logic [NUM_BK-1:0] ref_req;

    logic [NUM_BK-1:0] act_gnt;
    logic [NUM_BK-1:0] rd_gnt;
    logic [NUM_BK-1:0] wr_gnt;
    logic [NUM_BK-1:0] pre_gnt;
    logic [NUM_BK-1:0] ref_gnt;

    logic              cmd_valid;
    cmd_e              cmd_type;
    logic [BW-1:0]     cmd_bank;

    modport master (
        output act_req, rd_req, wr_req, pre_req, ref_req,
        input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        input  cmd_valid, cmd_type, cmd_bank
    );

    modport slave (
        input  act_req, rd_req, wr_req, pre_req, ref_req,
        output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        output cmd_valid, cmd_type, cmd_bank
    );

endinterface

// File: rtl/sal_rr_pick.sv
// ----------------------------------------------------------------------------
// sal_rr_pick
// Combinational round-robin picker. Searches i_req starting at i_ptr and
// wrapping modulo N; the first set bit wins.
//   i_req   [N]       request vector
//   i_ptr   [log2 N]  search start position
//   o_gnt   [N]       one-hot grant (zero when nothing requested)
//   o_idx   [log2 N]  index of the granted bit
//   o_found           any request present
// N must be a power of two so the pointer add wraps for free.
// ----------------------------------------------------------------------------
module sal_rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = i_ptr + IW'(i);
            if (!o_found && i_req[w_cand]) begin
                o_found       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// sal_cmd_arbiter
// DDR2 command arbiter between the per-bank controllers and the DFI command
// port. Grants at most one command per cycle: class priority
// PRE > RD > WR > ACT > REF, round-robin within a class from one shared
// pointer, with tCCD / tRRD / tWTR / tRTW spacing. The granted command is
// registered toward DFI with exactly one cycle of latency.
//   clk   clock, all state on the rising edge
//   rst   synchronous reset, active high; forces all grants low while high
//   bus   sal_cmd_arbiter_if.slave (requests in, grants + DFI command out)
// Build option: SAL_SCHED_AGING_EN adds a write-age counter; once writes have
// waited AGE_MAX cycles, WR ranks above RD and RD is held off so tRTW drains.
// ----------------------------------------------------------------------------
module sal_cmd_arbiter
    import sal_ddr2_pkg::*;
#(
    parameter int NUM_BK  = 8,
    parameter int T_CCD   = 2,
    parameter int T_RRD   = 2,
    parameter int T_WTR   = 4,
    parameter int T_RTW   = 4,
    parameter int AGE_MAX = 15
) (
    input logic               clk,
    input logic               rst,
    sal_cmd_arbiter_if.slave  bus
);

    localparam int BW = $clog2(NUM_BK);
    localparam int CW = spc_cnt_w(T_CCD, T_RRD, T_WTR, T_RTW);

    localparam logic [CW-1:0] CCD_LD = CW'(spc_load(T_CCD));
    localparam logic [CW-1:0] RRD_LD = CW'(spc_load(T_RRD));
    localparam logic [CW-1:0] WTR_LD = CW'(spc_load(T_WTR));
    localparam logic [CW-1:0] RTW_LD = CW'(spc_load(T_RTW));

    logic [BW-1:0] r_rr_ptr;
    logic [CW-1:0] r_ccd_cnt;
    logic [CW-1:0] r_rrd_cnt;
    logic [CW-1:0] r_wtr_cnt;
    logic [CW-1:0] r_rtw_cnt;
    logic          r_cmd_valid;
    cmd_e          r_cmd_type;
    logic [BW-1:0] r_cmd_bank;

    logic [NUM_BK-1:0] w_act_g, w_rd_g, w_wr_g, w_pre_g, w_ref_g;
    logic [BW-1:0]     w_act_i, w_rd_i, w_wr_i, w_pre_i, w_ref_i;
    logic              w_act_f, w_rd_f, w_wr_f, w_pre_f, w_ref_f;

    logic          w_wr_boost;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_act_ok;
    cmd_e          w_sel;
    logic [BW-1:0] w_sel_idx;

    // One picker per class, all sharing the same pointer.
    sal_rr_pick #(.N(NUM_BK)) u_pick_act (.i_req(bus.act_req), .i_ptr(r_rr_ptr),
        .o_gnt(w_act_g), .o_idx(w_act_i), .o_found(w_act_f));
    sal_rr_pick #(.N(NUM_BK)) u_pick_rd  (.i_req(bus.rd_req),  .i_ptr(r_rr_ptr),
        .o_gnt(w_rd_g),  .o_idx(w_rd_i),  .o_found(w_rd_f));
    sal_rr_pick #(.N(NUM_BK)) u_pick_wr  (.i_req(bus.wr_req),  .i_ptr(r_rr_ptr),
        .o_gnt(w_wr_g),  .o_idx(w_wr_i),  .o_found(w_wr_f));
    sal_rr_pick #(.N(NUM_BK)) u_pick_pre (.i_req(bus.pre_req), .i_ptr(r_rr_ptr),
        .o_gnt(w_pre_g), .o_idx(w_pre_i), .o_found(w_pre_f));
    sal_rr_pick #(.N(NUM_BK)) u_pick_ref (.i_req(bus.ref_req), .i_ptr(r_rr_ptr),
        .o_gnt(w_ref_g), .o_idx(w_ref_i), .o_found(w_ref_f));

`ifdef SAL_SCHED_AGING_EN
    localparam int AW = $clog2(AGE_MAX + 1);

    logic [AW-1:0] r_wr_age;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_age <= '0;
        end else if (w_sel == CMD_WR || !(|bus.wr_req)) begin
            r_wr_age <= '0;
        end else if (r_wr_age != AW'(AGE_MAX)) begin
            r_wr_age <= r_wr_age + AW'(1);
        end
    end

    assign w_wr_boost = (r_wr_age == AW'(AGE_MAX));
`else
    assign w_wr_boost = 1'b0;
`endif

    // While writes are starved, RD is held off as well: otherwise each RD grant
    // reloads tRTW and the boosted WR could never become eligible.
    assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wtr_cnt == '0) &&
                      !(w_wr_boost && (|bus.wr_req));
    assign w_wr_ok  = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);
    assign w_act_ok = (r_rrd_cnt == '0);

    // Ineligible classes fall through to the next one, so no idle bubble.
    always_comb begin
        w_sel     = CMD_NOP;
        w_sel_idx = '0;
        if (!rst) begin
            if (w_pre_f) begin
                w_sel     = CMD_PRE;
                w_sel_idx = w_pre_i;
            end else if (w_wr_boost && w_wr_ok && w_wr_f) begin
                w_sel     = CMD_WR;
                w_sel_idx = w_wr_i;
            end else if (w_rd_ok && w_rd_f) begin
                w_sel     = CMD_RD;
                w_sel_idx = w_rd_i;
            end else if (w_wr_ok && w_wr_f) begin
                w_sel     = CMD_WR;
                w_sel_idx = w_wr_i;
            end else if (w_act_ok && w_act_f) begin
                w_sel     = CMD_ACT;
                w_sel_idx = w_act_i;
            end else if (w_ref_f) begin
                w_sel     = CMD_REF;
                w_sel_idx = w_ref_i;
            end
        end
    end

    assign bus.act_gnt = (w_sel == CMD_ACT) ? w_act_g : '0;
    assign bus.rd_gnt  = (w_sel == CMD_RD)  ? w_rd_g  : '0;
    assign bus.wr_gnt  = (w_sel == CMD_WR)  ? w_wr_g  : '0;
    assign bus.pre_gnt = (w_sel == CMD_PRE) ? w_pre_g : '0;
    assign bus.ref_gnt = (w_sel == CMD_REF) ? w_ref_g : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_ccd_cnt   <= '0;
            r_rrd_cnt   <= '0;
            r_wtr_cnt   <= '0;
            r_rtw_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_NOP;
            r_cmd_bank  <= '0;
        end else begin
            // Spacing counters: load on the relevant grant, else count down to 0.
            if (w_sel == CMD_RD || w_sel == CMD_WR) r_ccd_cnt <= CCD_LD;
            else if (r_ccd_cnt != '0)               r_ccd_cnt <= r_ccd_cnt - CW'(1);

            if (w_sel == CMD_ACT)                   r_rrd_cnt <= RRD_LD;
            else if (r_rrd_cnt != '0)               r_rrd_cnt <= r_rrd_cnt - CW'(1);

            if (w_sel == CMD_WR)                    r_wtr_cnt <= WTR_LD;
            else if (r_wtr_cnt != '0)               r_wtr_cnt <= r_wtr_cnt - CW'(1);

            if (w_sel == CMD_RD)                    r_rtw_cnt <= RTW_LD;
            else if (r_rtw_cnt != '0)               r_rtw_cnt <= r_rtw_cnt - CW'(1);

            if (w_sel != CMD_NOP) begin
                r_rr_ptr    <= w_sel_idx + BW'(1);
                r_cmd_valid <= 1'b1;
                r_cmd_type  <= w_sel;
                r_cmd_bank  <= w_sel_idx;
            end else begin
                // cmd_bank deliberately holds its last value on idle cycles.
                r_cmd_valid <= 1'b0;
                r_cmd_type  <= CMD_NOP;
            end
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_type  = r_cmd_type;
    assign bus.cmd_bank  = r_cmd_bank;

endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sal_cmd_arbiter
// Self-checking bench for sal_cmd_arbiter. Two instances with different
// timings share the same request stimulus: dut_a (T_CCD=1) carries the
// directed sequences, both are compared against a cycle-based reference model
// during the random phase.
// ----------------------------------------------------------------------------
module tb_sal_cmd_arbiter;
    import sal_ddr2_pkg::*;

    localparam int N     = 8;
    localparam int AGE   = 15;
    localparam int A_CCD = 1, A_RRD = 2, A_WTR = 4, A_RTW = 4;
    localparam int B_CCD = 2, B_RRD = 3, B_WTR = 5, B_RTW = 3;
    localparam int FAR   = -100000;

    logic clk;
    logic rst;

    sal_cmd_arbiter_if #(.NUM_BK(N)) bus_a ();
    sal_cmd_arbiter_if #(.NUM_BK(N)) bus_b ();

    sal_cmd_arbiter #(.NUM_BK(N), .T_CCD(A_CCD), .T_RRD(A_RRD), .T_WTR(A_WTR),
                      .T_RTW(A_RTW), .AGE_MAX(AGE))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    sal_cmd_arbiter #(.NUM_BK(N), .T_CCD(B_CCD), .T_RRD(B_RRD), .T_WTR(B_WTR),
                      .T_RTW(B_RTW), .AGE_MAX(AGE))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / driver ----------------
    int checks = 0;
    int errors = 0;

    logic       cur_rst;
    logic [7:0] cur_act, cur_rd, cur_wr, cur_pre, cur_ref;

    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] rd,
                         input logic [7:0] w, input logic [7:0] p, input logic [7:0] f);
        rst = r;
        cur_rst = r; cur_act = a; cur_rd = rd; cur_wr = w; cur_pre = p; cur_ref = f;
        bus_a.act_req = a; bus_a.rd_req = rd; bus_a.wr_req = w; bus_a.pre_req = p; bus_a.ref_req = f;
        bus_b.act_req = a; bus_b.rd_req = rd; bus_b.wr_req = w; bus_b.pre_req = p; bus_b.ref_req = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Grant image: {act, rd, wr, pre, ref}.
    function automatic logic [39:0] exp_vec(input int cls, input int bank);
        logic [39:0] v;
        v = '0;
        case (cls)
            1: v[32 + bank] = 1'b1;
            2: v[24 + bank] = 1'b1;
            3: v[16 + bank] = 1'b1;
            4: v[8  + bank] = 1'b1;
            5: v[bank]      = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] cw(input int v, input int t, input int b);
        return {1'(v), 3'(t), 3'(b)};
    endfunction

    function automatic logic [39:0] gnt_a();
        return {bus_a.act_gnt, bus_a.rd_gnt, bus_a.wr_gnt, bus_a.pre_gnt, bus_a.ref_gnt};
    endfunction
    function automatic logic [39:0] gnt_b();
        return {bus_b.act_gnt, bus_b.rd_gnt, bus_b.wr_gnt, bus_b.pre_gnt, bus_b.ref_gnt};
    endfunction
    function automatic logic [6:0] cmd_a();
        return {bus_a.cmd_valid, 3'(bus_a.cmd_type), bus_a.cmd_bank};
    endfunction
    function automatic logic [6:0] cmd_b();
        return {bus_b.cmd_valid, 3'(bus_b.cmd_type), bus_b.cmd_bank};
    endfunction

    // ---------------- reference model ----------------
    // Spacing is tracked as "cycle of last grant of each kind"; a class is
    // eligible once enough cycles have elapsed since the relevant grant.
    int m_cyc[2], m_ptr[2], m_lcas[2], m_lact[2], m_lwr[2], m_lrd[2], m_age[2], m_cb[2];
    logic [6:0] exp_q_a[$];
    logic [6:0] exp_q_b[$];

    function automatic int rr_find(input logic [7:0] v, input int ptr);
        for (int i = 0; i < N; i++)
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [7:0] req_of(input int c);
        case (c)
            1: return cur_act;
            2: return cur_rd;
            3: return cur_wr;
            4: return cur_pre;
            default: return cur_ref;
        endcase
    endfunction

    task automatic model_reset(input int k);
        m_ptr[k] = 0; m_lcas[k] = FAR; m_lact[k] = FAR; m_lwr[k] = FAR; m_lrd[k] = FAR;
        m_age[k] = 0; m_cb[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [39:0] got_g, input logic [6:0] got_c);
        int tccd, trrd, twtr, trtw, cls, bank, b, cyc;
        int order[5];
        logic boost, pend, ok;
        logic [6:0] exp_c;
        tccd = (k == 0) ? A_CCD : B_CCD;
        trrd = (k == 0) ? A_RRD : B_RRD;
        twtr = (k == 0) ? A_WTR : B_WTR;
        trtw = (k == 0) ? A_RTW : B_RTW;
        cyc  = m_cyc[k];
        pend = |cur_wr;
        boost = 1'b0;
`ifdef SAL_SCHED_AGING_EN
        boost = (m_age[k] == AGE) && pend;
`endif
        if (boost) order = '{4, 3, 2, 1, 5};
        else       order = '{4, 2, 3, 1, 5};
        cls = 0; bank = 0;
        if (!cur_rst) begin
            for (int i = 0; i < 5; i++) begin
                case (order[i])
                    2: ok = (cyc - m_lcas[k] >= tccd) && (cyc - m_lwr[k] >= twtr) && !boost;
                    3: ok = (cyc - m_lcas[k] >= tccd) && (cyc - m_lrd[k] >= trtw);
                    1: ok = (cyc - m_lact[k] >= trrd);
                    default: ok = 1'b1;
                endcase
                b = rr_find(req_of(order[i]), m_ptr[k]);
                if (cls == 0 && ok && b >= 0) begin
                    cls = order[i];
                    bank = b;
                end
            end
        end
        check((k == 0) ? "rand_gnt_a" : "rand_gnt_b", 64'(got_g), 64'(exp_vec(cls, bank)));
        if (k == 0) exp_c = exp_q_a.pop_front();
        else        exp_c = exp_q_b.pop_front();
        check((k == 0) ? "rand_cmd_a" : "rand_cmd_b", 64'(got_c), 64'(exp_c));
        // advance to next cycle
        if (cur_rst) begin
            model_reset(k);
            exp_c = cw(0, 0, 0);
        end else begin
            if (cls != 0) begin
                m_ptr[k] = (bank + 1) % N;
                m_cb[k]  = bank;
                if (cls == 1) m_lact[k] = cyc;
                if (cls == 2) begin m_lrd[k] = cyc; m_lcas[k] = cyc; end
                if (cls == 3) begin m_lwr[k] = cyc; m_lcas[k] = cyc; end
                exp_c = cw(1, cls, bank);
            end else begin
                exp_c = cw(0, 0, m_cb[k]);
            end
            if (cls == 3 || !pend)   m_age[k] = 0;
            else if (m_age[k] < AGE) m_age[k] = m_age[k] + 1;
        end
        if (k == 0) exp_q_a.push_back(exp_c);
        else        exp_q_b.push_back(exp_c);
        m_cyc[k] = cyc + 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] act, rd, wr, pre, rf;
        int         e_cls;
        int         e_bank;
        logic [6:0] e_cmd;
    } vec_t;

    vec_t tbl[12];

    // ---------------- main test ----------------
    initial begin
        int wr_cnt, rd_cnt;
        int first_wr;
        logic [39:0] g;

        // Vectors for dut_a (T_CCD=1, T_RRD=2, T_WTR=4, T_RTW=4), applied from reset.
        // Priority sequence, then WR -> tWTR wait with ACTs at tRRD spacing.
        tbl[0]  = '{8'h20, 8'h02, 8'h00, 8'h08, 8'h01, 4, 3, cw(0, 0, 0)};
        tbl[1]  = '{8'h20, 8'h02, 8'h00, 8'h00, 8'h01, 2, 1, cw(1, 4, 3)};
        tbl[2]  = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 1, 5, cw(1, 2, 1)};
        tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 5, 0, cw(1, 1, 5)};
        tbl[4]  = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 0, 0, cw(1, 5, 0)};
        tbl[5]  = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 3, 4, cw(0, 0, 0)};
        tbl[6]  = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, cw(1, 3, 4)};
        tbl[7]  = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, cw(1, 1, 0)};
        tbl[8]  = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1, cw(0, 0, 0)};
        tbl[9]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 2, 0, cw(1, 1, 1)};
        tbl[10] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, cw(1, 2, 0)};
        tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, cw(0, 0, 0)};

        // 1: reset held 3 cycles with every request high
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_gnt_zero", 64'(gnt_a()), 64'(0));
            check("rst_cmd_valid", 64'(bus_a.cmd_valid), 64'(0));
            tick();
        end
        drive(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        @(negedge clk);
        check("rst_first_gnt", 64'(gnt_a()), 64'(exp_vec(4, 0)));
        check("rst_first_cmd", 64'(cmd_a()), 64'(cw(0, 0, 0)));
        tick();
        drive(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF);
        @(negedge clk);
        check("rst_cmd_pre0", 64'(cmd_a()), 64'(cw(1, 4, 0)));
        tick();

        // 2: round-robin fairness, rd_req=FF held
        do_reset();
        drive(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("rr_gnt", 64'(gnt_a()), 64'(exp_vec(2, k % N)));
            check("rr_cmd", 64'(cmd_a()), 64'((k == 0) ? cw(0, 0, 0) : cw(1, 2, (k - 1) % N)));
            tick();
        end

        // 3 + 4: table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, tbl[i].act, tbl[i].rd, tbl[i].wr, tbl[i].pre, tbl[i].rf);
            @(negedge clk);
            check($sformatf("tbl_gnt[%0d]", i), 64'(gnt_a()), 64'(exp_vec(tbl[i].e_cls, tbl[i].e_bank)));
            check($sformatf("tbl_cmd[%0d]", i), 64'(cmd_a()), 64'(tbl[i].e_cmd));
            tick();
        end

        // 5: write starvation / aging
        do_reset();
        drive(1'b0, 8'h00, 8'hFF, 8'h04, 8'h00, 8'h00);
        wr_cnt = 0; rd_cnt = 0; first_wr = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            g = gnt_a();
            if (g[23:16] != 8'h00) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = k;
            end
            if (g[31:24] != 8'h00) rd_cnt++;
            tick();
            if (first_wr >= 0) drive(1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
        end
`ifdef SAL_SCHED_AGING_EN
        check("aging_wr_granted", 64'(first_wr >= 0 && first_wr <= AGE + A_RTW), 64'(1));
        check("aging_wr_bank2_once", 64'(wr_cnt), 64'(1));
`else
        check("starve_wr_cnt", 64'(wr_cnt), 64'(0));
        check("starve_rd_cnt", 64'(rd_cnt), 64'(40));
`endif

        // 6: reset during the tWTR wait
        do_reset();
        drive(1'b0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        @(negedge clk);
        check("midrst_wr", 64'(gnt_a()), 64'(exp_vec(3, 0)));
        tick();
        drive(1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("midrst_wtr_block", 64'(gnt_a()), 64'(0));
        tick();
        drive(1'b1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("midrst_rst_gnt", 64'(gnt_a()), 64'(0));
        tick();
        drive(1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("midrst_rd_now", 64'(gnt_a()), 64'(exp_vec(2, 0)));
        check("midrst_cmd", 64'(cmd_a()), 64'(cw(0, 0, 0)));
        tick();

        // Random phase: both instances against the model
        do_reset();
        model_reset(0); model_reset(1);
        m_cyc[0] = 0; m_cyc[1] = 0;
        exp_q_a.delete(); exp_q_b.delete();
        exp_q_a.push_back(cw(0, 0, 0));
        exp_q_b.push_back(cw(0, 0, 0));
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 99) == 0,
                  8'($urandom) & 8'($urandom),
                  8'($urandom) & 8'($urandom) & 8'($urandom),
                  8'($urandom) & 8'($urandom),
                  8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom),
                  8'($urandom) & 8'($urandom));
            @(negedge clk);
            model_step(0, gnt_a(), cmd_a());
            model_step(1, gnt_b(), cmd_b());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
